// File: rtl/key_spi_slave.sv
// rtl/key_spi_slave.sv - key-code FIFO behind a mode-0 SPI slave with an active-low interrupt
// Codes arrive on the debouncer strobe; the SPI master reads one {valid, overrun, 00, code} byte per frame.
module key_spi_slave #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  FLUSH_CMD  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_bar,
   input  logic [3:0] key_code,
   input  logic       term,
   input  logic       sclk,
   input  logic       ss_bar,
   input  logic       mosi,
   output logic       miso,
   output logic       int_bar
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t state, next_state;

   logic sclk_s1, sclk_s2, sclk_d;
   logic ss_s1, ss_s2, ss_d;
   logic mosi_s1, mosi_s2;
   logic sclk_rise, sclk_fall, ss_fall;

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          overrun;
   logic          non_empty, full;
   logic          do_push, do_pop, do_flush;
   logic [7:0]    resp;

   logic [7:0] tx_sr, rx_sr;
   logic [3:0] bit_cnt;
   logic       snap_valid, snap_ovr;
   logic       miso_q;

   // 2-flop synchronizers plus one edge-detect copy; ss_bar idles high
   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_d    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         ss_s1   <= ss_bar;
         ss_s2   <= ss_s1;
         ss_d    <= ss_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign ss_fall   = ~ss_s2 & ss_d;

   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ss_fall) next_state = LOAD;
         LOAD:    next_state = SHIFT;
         SHIFT:   if (sclk_rise && bit_cnt == 4'd7) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (ss_s2) next_state = IDLE;
   end

   assign non_empty = (count != '0);
   assign full      = (count == FULL_CNT);
   assign resp      = {non_empty, overrun, 2'b00, non_empty ? mem[rd_ptr] : 4'h0};

   // Flush beats both the frame pop and any concurrent push
   assign do_flush = (state == DONE) && (rx_sr == FLUSH_CMD);
   assign do_pop   = (state == DONE) && snap_valid && !do_flush;
   assign do_push  = term && !do_flush && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= key_code;
   end

   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else if (do_flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
         // A fresh drop outranks clearing the overrun the master just saw
         if (term && full && !do_pop)        overrun <= 1'b1;
         else if ((state == DONE) && snap_ovr) overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         tx_sr      <= 8'h00;
         rx_sr      <= 8'h00;
         bit_cnt    <= 4'd0;
         snap_valid <= 1'b0;
         snap_ovr   <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: miso_q <= 1'b0;
            LOAD: begin
               tx_sr      <= resp;
               rx_sr      <= 8'h00;
               snap_valid <= resp[7];
               snap_ovr   <= resp[6];
               bit_cnt    <= 4'd0;
               miso_q     <= resp[7];
            end
            SHIFT: begin
               if (sclk_rise) begin
                  rx_sr   <= {rx_sr[6:0], mosi_s2};
                  bit_cnt <= bit_cnt + 4'd1;
               end
               if (sclk_fall) begin
                  tx_sr  <= {tx_sr[6:0], 1'b0};
                  miso_q <= tx_sr[6];
               end
            end
            default: ;
         endcase
      end
   end

   assign miso = (state == IDLE) ? 1'b0 : miso_q;

   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) int_bar <= 1'b1;
      else          int_bar <= ~(non_empty | overrun);
   end

endmodule

// File: tb/tb_key_spi_slave.sv
// tb/tb_key_spi_slave.sv - directed table, corner sequences and randomized model check for key_spi_slave
// Inputs change on clk falling edges; outputs are sampled on falling edges.
module tb_key_spi_slave;

   logic       clk = 1'b0;
   logic       rst_bar = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       term = 1'b0;
   logic       sclk = 1'b0;
   logic       ss_bar = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       int_bar;

   int total = 0;
   int bad = 0;

   localparam int OP_PUSH  = 0;
   localparam int OP_FRAME = 1;
   localparam int OP_ABORT = 2;
   localparam int OP_INT   = 3;

   typedef struct {
      int         op;
      logic [7:0] arg;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[$];

   logic [3:0] mq[$];
   bit         m_ovr;

   key_spi_slave #(.FIFO_DEPTH(4), .FLUSH_CMD(8'hA5)) dut (
      .clk(clk), .rst_bar(rst_bar), .key_code(key_code), .term(term),
      .sclk(sclk), .ss_bar(ss_bar), .mosi(mosi), .miso(miso), .int_bar(int_bar)
   );

   always #10 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   function automatic void add(input int op, input logic [7:0] a, input logic [7:0] e);
      vec_t v;
      v.op = op;
      v.arg = a;
      v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic push_code(input logic [3:0] c);
      key_code = c;
      term = 1'b1;
      @(negedge clk);
      term = 1'b0;
      @(negedge clk);
   endtask

   // nrises < 8 aborts the frame; inject pushes icode in the clk of the DONE pop
   task automatic spi_frame(input logic [7:0] txb, input int nrises, input bit inject,
                            input logic [3:0] icode, output logic [7:0] rxb);
      rxb = 8'h00;
      ss_bar = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nrises; i++) begin
         mosi = txb[7-i];
         repeat (2) @(negedge clk);
         rxb[7-i] = miso;
         sclk = 1'b1;
         if (i == 7 && inject) begin
            repeat (3) @(negedge clk);
            key_code = icode;
            term = 1'b1;
            @(negedge clk);
            term = 1'b0;
            @(negedge clk);
         end else begin
            repeat (5) @(negedge clk);
         end
         sclk = 1'b0;
         repeat (5) @(negedge clk);
      end
      ss_bar = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   function automatic logic [7:0] model_resp();
      logic v;
      v = (mq.size() != 0);
      return {v, m_ovr, 2'b00, v ? mq[0] : 4'h0};
   endfunction

   function automatic logic [7:0] model_int();
      return {7'b0, !((mq.size() != 0) || m_ovr)};
   endfunction

   initial begin
      logic [7:0] r;
      logic [7:0] e;
      logic [7:0] tx;
      logic [3:0] c;
      int sel;
      int nr;

      // Reset held while the debouncer keeps strobing
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         term = ~term;
         key_code = 4'(i + 3);
      end
      check("rst_miso", {7'b0, miso}, 8'h00);
      check("rst_int", {7'b0, int_bar}, 8'h01);
      term = 1'b0;
      @(negedge clk);
      rst_bar = 1'b1;
      repeat (3) @(negedge clk);

      add(OP_FRAME, 8'h00, 8'h00);
      add(OP_INT,   8'h00, 8'h01);
      add(OP_PUSH,  8'h07, 8'h00);
      add(OP_INT,   8'h00, 8'h00);
      add(OP_FRAME, 8'h00, 8'h87);
      add(OP_INT,   8'h00, 8'h01);
      add(OP_FRAME, 8'h00, 8'h00);
      for (int i = 1; i <= 5; i++) add(OP_PUSH, 8'(i), 8'h00);
      add(OP_FRAME, 8'h00, 8'hC1);
      add(OP_FRAME, 8'h00, 8'h82);
      add(OP_FRAME, 8'h00, 8'h83);
      add(OP_FRAME, 8'h00, 8'h84);
      add(OP_FRAME, 8'h00, 8'h00);
      add(OP_INT,   8'h00, 8'h01);
      add(OP_PUSH,  8'h09, 8'h00);
      add(OP_ABORT, 8'd5,  8'h00);
      add(OP_INT,   8'h00, 8'h00);
      add(OP_FRAME, 8'h00, 8'h89);
      add(OP_INT,   8'h00, 8'h01);
      add(OP_PUSH,  8'h0A, 8'h00);
      add(OP_PUSH,  8'h0B, 8'h00);
      add(OP_FRAME, 8'hA5, 8'h8A);
      add(OP_INT,   8'h00, 8'h01);
      add(OP_FRAME, 8'h00, 8'h00);

      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_PUSH:  push_code(tbl[i].arg[3:0]);
            OP_FRAME: begin
               spi_frame(tbl[i].arg, 8, 1'b0, 4'h0, r);
               check($sformatf("tbl%0d_frame", i), r, tbl[i].exp);
            end
            OP_ABORT: spi_frame(8'hA5, int'(tbl[i].arg), 1'b0, 4'h0, r);
            default:  check($sformatf("tbl%0d_int", i), {7'b0, int_bar}, tbl[i].exp);
         endcase
      end

      // Full FIFO, push lands in the same clk as the frame pop
      for (int i = 1; i <= 4; i++) push_code(4'(i));
      spi_frame(8'h00, 8, 1'b1, 4'hE, r);
      check("pp_frame0", r, 8'h81);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("pp_frame1", r, 8'h82);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("pp_frame2", r, 8'h83);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("pp_frame3", r, 8'h84);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("pp_frame4", r, 8'h8E);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("pp_empty", r, 8'h00);

      // Reset in the middle of a frame
      push_code(4'h6);
      ss_bar = 1'b0;
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      rst_bar = 1'b0;
      @(negedge clk);
      check("midrst_miso", {7'b0, miso}, 8'h00);
      check("midrst_int", {7'b0, int_bar}, 8'h01);
      sclk = 1'b0;
      ss_bar = 1'b1;
      @(negedge clk);
      rst_bar = 1'b1;
      repeat (4) @(negedge clk);
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("midrst_frame", r, 8'h00);

      mq.delete();
      m_ovr = 1'b0;
      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 45) begin
            c = 4'($urandom_range(0, 15));
            if (mq.size() < 4) mq.push_back(c);
            else m_ovr = 1'b1;
            push_code(c);
            check($sformatf("rnd%0d_push_int", n), {7'b0, int_bar}, model_int());
         end else if (sel < 85) begin
            tx = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
            e = model_resp();
            spi_frame(tx, 8, 1'b0, 4'h0, r);
            check($sformatf("rnd%0d_frame", n), r, e);
            if (tx == 8'hA5) begin
               mq.delete();
               m_ovr = 1'b0;
            end else begin
               if (e[7]) void'(mq.pop_front());
               if (e[6]) m_ovr = 1'b0;
            end
            check($sformatf("rnd%0d_frame_int", n), {7'b0, int_bar}, model_int());
         end else begin
            nr = int'($urandom_range(0, 7));
            spi_frame(8'hA5, nr, 1'b0, 4'h0, r);
            check($sformatf("rnd%0d_abort_int", n), {7'b0, int_bar}, model_int());
         end
      end
      e = model_resp();
      spi_frame(8'h00, 8, 1'b0, 4'h0, r);
      check("rnd_final", r, e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_spi_slave.md
# key_spi_slave

Receives debounced key codes from the keypad front end and queues them in a small FIFO. Each code is captured on the debouncer's one-cycle `term` strobe. An external SPI master is alerted through an active-low interrupt and reads one code per 8-bit SPI frame. The block sits directly downstream of the debouncer and is the only path from the keypad to the off-chip controller.

## Interface
- `FIFO_DEPTH`, 4: key-code queue depth; must be a power of 2, ≥2.
- `FLUSH_CMD`, 8'hA5: MOSI byte that flushes the FIFO and clears overrun.
- `clk`  in  1  system clock, 50 MHz.
- `rst_bar`  in  1  reset; asynchronous, active-low.
- `key_code`  in  4  key code from the key encoder; valid when `term`=1.
- `term`  in  1  one-clk strobe from the debouncer; push `key_code`.
- `sclk`  in  1  SPI clock from the master, mode 0, asynchronous to `clk`.
- `ss_bar`  in  1  SPI slave select, active-low, asynchronous.
- `mosi`  in  1  SPI data from the master, asynchronous.
- `miso`  out  1  SPI data to the master; driven 0 when not selected.
- `int_bar`  out  1  low while the FIFO is non-empty or overrun is set.

## Operation
- `sclk`, `ss_bar` and `mosi` each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals by comparing against a third registered copy.
- FIFO:
  - Circular buffer with wrap-around read and write pointers and an occupancy count.
  - `term`=1 and not full: write `key_code`.
  - `term`=1 and full: drop the code and set sticky `overrun`.
- Response byte = {valid, overrun, 2'b00, code[3:0]}.
  - valid = FIFO non-empty.
  - code = FIFO head, or 4'h0 when empty.
- SPI FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE → LOAD on synchronized `ss_bar` falling edge.
  - LOAD: snapshot the response byte into the TX shift register, latch snapshot valid/overrun, set bit count to 0, drive TX[7] on `miso`. Go to SHIFT.
  - SHIFT, `sclk` rising edge: shift synchronized `mosi` into the RX register LSB; increment bit count.
  - SHIFT, `sclk` falling edge: shift TX left and drive the new MSB on `miso`.
  - SHIFT → DONE after the 8th rising edge.
  - DONE, one clk:
    - If snapshot valid: pop the FIFO.
    - If snapshot overrun: clear `overrun`.
    - If RX == `FLUSH_CMD`: empty the FIFO (pointers and count to 0) and clear `overrun`. Flush takes priority over pop.
    - DONE → IDLE.
  - Any state: synchronized `ss_bar` high → IDLE immediately. An aborted frame with fewer than 8 rising edges does not pop, does not clear overrun and does not flush.
  - Additional `sclk` edges after DONE and before `ss_bar` rises are ignored.
- `miso` = 0 in IDLE.
- `int_bar` = ~(non-empty | overrun), registered.
- Simultaneous push and pop in the same clk:
  - Both take effect and the count is unchanged.
  - When the FIFO is full, the pop frees a slot, so the push succeeds and `overrun` is not set.
- Simultaneous push and flush: flush wins and the pushed code is discarded.
- Reset (asynchronous, any time, including mid-frame):
  - FIFO empty, `overrun`=0, FSM=IDLE.
  - `miso`=0, `int_bar`=1.
  - Synchronizer flops: `ss_bar` chain to 1, `sclk` and `mosi` chains to 0.

## Timing
- `term` at clk edge N → entry written at N. `int_bar` falls after edge N+1.
- Pin-to-internal latency for SPI edges is 3 clk (2 sync + 1 edge register).
- `sclk` high and low phases must each be ≥4 clk (≤6.25 MHz).
- `ss_bar` fall to first `sclk` rise must be ≥5 clk.
- `miso` updates 3–4 clk after the `sclk` falling pin edge, and 4 clk after the `ss_bar` fall for bit 7.
- Response data is fixed at LOAD. Pushes during a frame appear in the next frame.
- Pop/flush occurs at DONE, 4 clk after the 8th `sclk` rising pin edge. `int_bar` updates 1 clk later.

## Test plan
- Reset: hold `rst_bar`=0 with `term` pulsing → `miso`=0, `int_bar`=1; a frame then returns 8'h00.
- Push 4'h7, then one frame with MOSI 8'h00 → MISO 8'h87. `int_bar` rises after DONE. The next frame returns 8'h00.
- Push 4'h1, 4'h2, 4'h3, 4'h4, 4'h5 (depth 4) → `overrun` set. Frames return 8'hC1, 8'h82, 8'h83, 8'h84, then 8'h00. Code 4'h5 is never returned.
- Push 4'h9. Raise `ss_bar` after 5 `sclk` rising edges → no pop. The next full frame returns 8'h89.
- Push 4'hA and 4'hB, then a frame with MOSI 8'hA5 → that frame returns 8'h8A. FIFO is empty afterwards, `int_bar`=1, and the next frame returns 8'h00.
- Fill the FIFO, then `term` in the same clk as a DONE pop → count stays 4, `overrun` stays 0, and the new code is read last.
